// File: rtl/prog_mem_if.sv
// Fetch/load bus for prog_mem; the parity pins exist only when PROG_MEM_PARITY_EN is defined.
// master = the CPU/loader side, slave = the memory.
interface prog_mem_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic [DATA_W-1:0] fetch_data;
  logic              fetch_valid;
  logic              load_start;
  logic              load_valid;
  logic              load_last;
  logic [DATA_W-1:0] load_data;
  logic              load_ready;
  logic              load_done;
  logic              busy;
`ifdef PROG_MEM_PARITY_EN
  logic              fetch_perr;
  logic              load_par_flip;

  modport master (
    output fetch_req, fetch_addr, load_start, load_valid, load_last, load_data, load_par_flip,
    input  fetch_data, fetch_valid, load_ready, load_done, busy, fetch_perr
  );
  modport slave (
    input  fetch_req, fetch_addr, load_start, load_valid, load_last, load_data, load_par_flip,
    output fetch_data, fetch_valid, load_ready, load_done, busy, fetch_perr
  );
`else
  modport master (
    output fetch_req, fetch_addr, load_start, load_valid, load_last, load_data,
    input  fetch_data, fetch_valid, load_ready, load_done, busy
  );
  modport slave (
    input  fetch_req, fetch_addr, load_start, load_valid, load_last, load_data,
    output fetch_data, fetch_valid, load_ready, load_done, busy
  );
`endif
endinterface

// File: rtl/prog_mem.sv
// Program memory: boots a default image, serves 1-cycle fetches, accepts streamed reloads.
// Optional even-parity per word when PROG_MEM_PARITY_EN is defined.
module prog_mem #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic      clk,
  input  logic      reset,
  prog_mem_if.slave bus
);
  localparam int DEPTH = 2**ADDR_W;

  typedef enum logic [1:0] {BOOT, IDLE, LOAD} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              load_done_q, load_done_d;
  logic              fetch_valid_q, fetch_valid_d;
  logic [DATA_W-1:0] fetch_data_q;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic              ptr_at_end;

  logic [DATA_W-1:0] mem [DEPTH];

  function automatic logic [DATA_W-1:0] boot_word(input logic [ADDR_W-1:0] a);
    logic [7:0] w;
    case (int'(a))
      0:       w = 8'hB0;
      1:       w = 8'h08;
      2:       w = 8'h19;
      3:       w = 8'h20;
      4:       w = 8'h10;
      5:       w = 8'h70;
      6:       w = 8'h00;
      7:       w = 8'h14;
      8:       w = 8'h04;
      9:       w = 8'hB2;
      default: w = 8'hB0;
    endcase
    return DATA_W'(w);
  endfunction

  assign ptr_at_end = (ptr_q == ADDR_W'(DEPTH-1));

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    load_done_d   = 1'b0;
    fetch_valid_d = 1'b0;
    wr_en         = 1'b0;
    wr_data       = boot_word(ptr_q);
    rd_en         = 1'b0;
    case (state_q)
      BOOT: begin
        wr_en = 1'b1;
        ptr_d = ptr_q + ADDR_W'(1);
        if (ptr_at_end) begin
          state_d = IDLE;
          ptr_d   = '0;
        end
      end
      IDLE: begin
        // A load request wins; a fetch in the same cycle is dropped.
        if (bus.load_start) begin
          state_d = LOAD;
          ptr_d   = '0;
        end else if (bus.fetch_req) begin
          rd_en         = 1'b1;
          fetch_valid_d = 1'b1;
        end
      end
      LOAD: begin
        wr_data = bus.load_data;
        if (bus.load_valid) begin
          wr_en = 1'b1;
          ptr_d = ptr_q + ADDR_W'(1);
          if (bus.load_last || ptr_at_end) begin
            state_d     = IDLE;
            load_done_d = 1'b1;
            ptr_d       = '0;
          end
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= BOOT;
      ptr_q         <= '0;
      load_done_q   <= 1'b0;
      fetch_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      load_done_q   <= load_done_d;
      fetch_valid_q <= fetch_valid_d;
    end
  end

  // Storage has no reset; BOOT rewrites every word after each reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_data_q <= '0;
    end else if (rd_en) begin
      fetch_data_q <= mem[bus.fetch_addr];
    end
  end

`ifdef PROG_MEM_PARITY_EN
  logic par_mem [DEPTH];
  logic par_q;
  logic wr_par;

  assign wr_par = (^wr_data) ^ ((state_q == LOAD) && bus.load_par_flip);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      par_mem[ptr_q] <= wr_par;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      par_q <= 1'b0;
    end else if (rd_en) begin
      par_q <= par_mem[bus.fetch_addr];
    end
  end

  assign bus.fetch_perr = fetch_valid_q & (par_q ^ (^fetch_data_q));
`endif

  assign bus.fetch_data  = fetch_data_q;
  assign bus.fetch_valid = fetch_valid_q;
  assign bus.load_done   = load_done_q;
  assign bus.load_ready  = (state_q == LOAD);
  assign bus.busy        = (state_q != IDLE);
endmodule
